stk_pipe_wrbk: RTL



---
 rtl/stk_pipe_wrbk.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stk_pipe_wrbk.sv
// Writeback stage of the stack pipeline: registers the MEM-stage update back to LK and
// queues one response per command. Optional statistics counters under STK_WRBK_CNT_EN.
module stk_pipe_wrbk #(
    parameter int ENGS_N  = 4,
    parameter int BANKS_N = 4,
    parameter int PTR_W   = 8,
    parameter int RSP_N   = 4,
    localparam int ENG_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int BANK_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   i_mem_uc_vld_r,
    input  logic [ENG_W-1:0]       i_mem_uc_engid_r,
    input  logic [1:0]             i_mem_uc_opcode_r,
    input  logic [BANK_W-1:0]      i_mem_uc_bankid_r,
    input  logic                   i_mem_uc_ok_r,
    input  logic                   i_mem_uc_set_empty_r,
    input  logic                   i_mem_uc_clr_empty_r,
    input  logic                   i_mem_uc_head_vld_r,
    input  logic [PTR_W-1:0]       i_mem_uc_head_ptr_r,
    input  logic                   i_mem_uc_tail_vld_r,
    input  logic [PTR_W-1:0]       i_mem_uc_tail_ptr_r,
    input  logic [BANKS_N*128-1:0] i_mem_dat_rdata,
    output logic                   o_wrbk_uc_vld_r,
    output logic [ENG_W-1:0]       o_wrbk_uc_engid_r,
    output logic                   o_wrbk_uc_set_empty_r,
    output logic                   o_wrbk_uc_clr_empty_r,
    output logic                   o_wrbk_uc_head_vld_r,
    output logic [PTR_W-1:0]       o_wrbk_uc_head_ptr_r,
    output logic                   o_wrbk_uc_tail_vld_r,
    output logic [PTR_W-1:0]       o_wrbk_uc_tail_ptr_r,
    output logic                   o_rsp_vld,
    input  logic                   i_rsp_rdy,
    output logic [ENG_W-1:0]       o_rsp_engid,
    output logic [1:0]             o_rsp_opcode,
    output logic                   o_rsp_ok,
    output logic [127:0]           o_rsp_dat,
    output logic                   o_busy_r,
    output logic                   o_ovf_r,
    output logic [31:0]            o_cnt_push,
    output logic [31:0]            o_cnt_pop,
    output logic [31:0]            o_cnt_err
);

    localparam int RP_W = $clog2(RSP_N);
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    logic accept;
    logic illegal;

    assign accept  = i_mem_uc_vld_r && (i_mem_uc_opcode_r != OP_NOP);
    assign illegal = i_mem_uc_set_empty_r && i_mem_uc_clr_empty_r;

    // Conflicting empty updates resolve toward set_empty so LK never loses an empty mark.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            o_wrbk_uc_vld_r       <= 1'b0;
            o_wrbk_uc_engid_r     <= '0;
            o_wrbk_uc_set_empty_r <= 1'b0;
            o_wrbk_uc_clr_empty_r <= 1'b0;
            o_wrbk_uc_head_vld_r  <= 1'b0;
            o_wrbk_uc_head_ptr_r  <= '0;
            o_wrbk_uc_tail_vld_r  <= 1'b0;
            o_wrbk_uc_tail_ptr_r  <= '0;
        end else begin
            o_wrbk_uc_vld_r <= accept;
            if (accept) begin
                o_wrbk_uc_engid_r     <= i_mem_uc_engid_r;
                o_wrbk_uc_set_empty_r <= i_mem_uc_set_empty_r;
                o_wrbk_uc_clr_empty_r <= i_mem_uc_clr_empty_r && !illegal;
                o_wrbk_uc_head_vld_r  <= i_mem_uc_head_vld_r;
                o_wrbk_uc_head_ptr_r  <= i_mem_uc_head_ptr_r;
                o_wrbk_uc_tail_vld_r  <= i_mem_uc_tail_vld_r;
                o_wrbk_uc_tail_ptr_r  <= i_mem_uc_tail_ptr_r;
            end
        end
    end

    logic [127:0] bank_dat;
    logic [127:0] rsp_dat_in;

    always_comb begin
        bank_dat = '0;
        for (int b = 0; b < BANKS_N; b++) begin
            if (i_mem_uc_bankid_r == BANK_W'(b)) begin
                bank_dat = i_mem_dat_rdata[b*128 +: 128];
            end
        end
        rsp_dat_in = (i_mem_uc_opcode_r == OP_POP && i_mem_uc_ok_r) ? bank_dat : '0;
    end

    // Response handshake: a response transfers on any cycle where o_rsp_vld && i_rsp_rdy;
    // while o_rsp_vld=1 and i_rsp_rdy=0 the payload is held unchanged.
    logic [RP_W:0]      wr_ptr;
    logic [RP_W:0]      rd_ptr;
    logic [RP_W:0]      occ;
    logic [RP_W:0]      occ_nxt;
    logic               q_empty;
    logic               q_full;
    logic               enq;
    logic               deq;
    logic [ENG_W-1:0]   q_engid  [RSP_N];
    logic [1:0]         q_opcode [RSP_N];
    logic               q_ok     [RSP_N];
    logic [127:0]       q_dat    [RSP_N];
    logic [RP_W-1:0]    rd_idx;
    logic [RP_W-1:0]    wr_idx;

    assign occ     = wr_ptr - rd_ptr;
    assign q_empty = (occ == '0);
    assign q_full  = (occ == (RP_W+1)'(RSP_N));
    assign deq     = !q_empty && i_rsp_rdy;
    assign enq     = accept && (!q_full || deq);
    assign occ_nxt = occ + (RP_W+1)'(enq) - (RP_W+1)'(deq);
    assign rd_idx  = rd_ptr[RP_W-1:0];
    assign wr_idx  = wr_ptr[RP_W-1:0];

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_busy_r <= 1'b0;
            o_ovf_r  <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            o_busy_r <= (occ_nxt > (RP_W+1)'(RSP_N - 2));
            if (accept && q_full && !deq) o_ovf_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_engid[wr_idx]  <= i_mem_uc_engid_r;
            q_opcode[wr_idx] <= i_mem_uc_opcode_r;
            q_ok[wr_idx]     <= i_mem_uc_ok_r;
            q_dat[wr_idx]    <= rsp_dat_in;
        end
    end

    assign o_rsp_vld    = !q_empty;
    assign o_rsp_engid  = q_empty ? '0 : q_engid[rd_idx];
    assign o_rsp_opcode = q_empty ? '0 : q_opcode[rd_idx];
    assign o_rsp_ok     = q_empty ? 1'b0 : q_ok[rd_idx];
    assign o_rsp_dat    = q_empty ? '0 : q_dat[rd_idx];

`ifdef STK_WRBK_CNT_EN
    logic inc_push;
    logic inc_pop;
    logic inc_err;

    assign inc_push = accept && (i_mem_uc_opcode_r == OP_PUSH) && i_mem_uc_ok_r;
    assign inc_pop  = accept && (i_mem_uc_opcode_r == OP_POP) && i_mem_uc_ok_r;
    assign inc_err  = accept && (!i_mem_uc_ok_r || illegal);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            o_cnt_push <= '0;
            o_cnt_pop  <= '0;
            o_cnt_err  <= '0;
        end else begin
            if (inc_push && (o_cnt_push != '1)) o_cnt_push <= o_cnt_push + 32'd1;
            if (inc_pop  && (o_cnt_pop  != '1)) o_cnt_pop  <= o_cnt_pop + 32'd1;
            if (inc_err  && (o_cnt_err  != '1)) o_cnt_err  <= o_cnt_err + 32'd1;
        end
    end
`else
    assign o_cnt_push = '0;
    assign o_cnt_pop  = '0;
    assign o_cnt_err  = '0;
`endif

endmodule
